tt_mask_idx_rx: RTL and testbench

Receiver for the VPU mask/index credit channel, on the LSU side. Buffers 65-bit mask/index items in a MASK_CREDITS-deep FIFO and returns one credit per freed entry. Unpacks the items into a per-element stream (mask bit plus optional 64-bit index) for the LSU address generator. Strided/unit-stride memops arrive as 64-bit mask chunks; indexed memops arrive as one item per element.

---
 rtl/tt_vpu_mask_pkg.sv | 20 ++
 rtl/tt_mask_idx_rx_if.sv | 13 +
 rtl/tt_mask_idx_fifo.sv | 58 +++++
 rtl/tt_mask_idx_rx.sv | 128 ++++++++++++
 tb/tb_tt_mask_idx_rx.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tt_vpu_mask_pkg.sv
// Shared types for the VPU mask/index credit channel, used by the LSU-side
// receiver and by the transmitter.
package tt_vpu_mask_pkg;

  localparam int MASK_IDX_ITEM_W   = 65;
  localparam int MASK_IDX_MASK_BIT = 64;

  typedef logic [MASK_IDX_ITEM_W-1:0] mask_idx_item_t;

  typedef struct packed {
    logic           last_idx;
    mask_idx_item_t item;
  } mask_idx_entry_t;

  typedef enum logic {
    IDLE,
    ACTIVE
  } rx_state_e;

endpackage

// File: rtl/tt_mask_idx_rx_if.sv
// Mask/index credit channel: item push towards the LSU, credit return to the VPU.
interface tt_mask_idx_rx_if;
  import tt_vpu_mask_pkg::*;

  logic           valid;
  mask_idx_item_t item;
  logic           last_idx;
  logic           credit;

  modport master (output valid, output item, output last_idx, input credit);
  modport slave  (input valid, input item, input last_idx, output credit);

endinterface

// File: rtl/tt_mask_idx_fifo.sv
// Small synchronous FIFO with a registered head; a push while full is only
// taken when a pop frees an entry in the same cycle.
module tt_mask_idx_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 66
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr_reg];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/tt_mask_idx_rx.sv
// LSU-side receiver: buffers mask/index items, returns credits, and unpacks
// them into a per-element mask/index stream for the address generator.
module tt_mask_idx_rx
  import tt_vpu_mask_pkg::*;
#(
  parameter int VLEN         = 256,
  parameter int MASK_CREDITS = 2
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  tt_mask_idx_rx_if.slave            mask_idx,
  input  logic                       i_start,
  input  logic                       i_is_indexed,
  input  logic [$clog2(VLEN+1)-1:0]  i_vl,
  output logic                       o_elem_valid,
  input  logic                       i_elem_ready,
  output logic                       o_elem_mask,
  output logic [63:0]                o_elem_index,
  output logic                       o_elem_last,
  output logic                       o_busy,
  output logic                       o_protocol_err
);

  localparam int VLW = $clog2(VLEN + 1);

  rx_state_e       state_reg, state_next;
  logic            indexed_reg, indexed_next;
  logic [VLW-1:0]  vl_reg, vl_next;
  logic [VLW-1:0]  elem_cnt_reg, elem_cnt_next;
  logic [5:0]      bit_ptr_reg, bit_ptr_next;
  logic            err_reg, err_next;
  logic            credit_reg;

  mask_idx_entry_t push_entry;
  mask_idx_entry_t head;
  logic            fifo_full;
  logic            fifo_empty;
  logic            active;
  logic            consume;
  logic            pop;

  assign push_entry = '{last_idx: mask_idx.last_idx, item: mask_idx.item};

  tt_mask_idx_fifo #(
    .DEPTH (MASK_CREDITS),
    .WIDTH ($bits(mask_idx_entry_t))
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .push      (mask_idx.valid),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign active       = (state_reg == ACTIVE);
  assign o_busy       = active;
  assign o_elem_valid = active && !fifo_empty;
  assign o_elem_last  = active && (elem_cnt_reg == vl_reg - VLW'(1));
  assign consume      = o_elem_valid && i_elem_ready;
  // A mask chunk retires after its 64th bit or on the memop's final element.
  assign pop          = consume && (indexed_reg || bit_ptr_reg == 6'd63 || o_elem_last);

  // Gated by valid so the unreset FIFO storage never leaks onto the outputs.
  assign o_elem_mask  = o_elem_valid &&
                        (indexed_reg ? head.item[MASK_IDX_MASK_BIT] : head.item[bit_ptr_reg]);
  assign o_elem_index = (o_elem_valid && indexed_reg) ? head.item[63:0] : 64'd0;

  assign mask_idx.credit = credit_reg;
  assign o_protocol_err  = err_reg;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg    <= IDLE;
      indexed_reg  <= 1'b0;
      vl_reg       <= '0;
      elem_cnt_reg <= '0;
      bit_ptr_reg  <= '0;
      err_reg      <= 1'b0;
      credit_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      indexed_reg  <= indexed_next;
      vl_reg       <= vl_next;
      elem_cnt_reg <= elem_cnt_next;
      bit_ptr_reg  <= bit_ptr_next;
      err_reg      <= err_next;
      credit_reg   <= pop;
    end
  end

  always_comb begin
    state_next    = state_reg;
    indexed_next  = indexed_reg;
    vl_next       = vl_reg;
    elem_cnt_next = elem_cnt_reg;
    bit_ptr_next  = bit_ptr_reg;
    err_next      = err_reg;

    if (mask_idx.valid && fifo_full && !pop) err_next = 1'b1;

    case (state_reg)
      IDLE: begin
        if (i_start && i_vl != '0) begin
          state_next    = ACTIVE;
          indexed_next  = i_is_indexed;
          vl_next       = i_vl;
          elem_cnt_next = '0;
          bit_ptr_next  = '0;
        end
      end
      ACTIVE: begin
        if (i_start) err_next = 1'b1;
        if (consume) begin
          elem_cnt_next = elem_cnt_reg + VLW'(1);
          bit_ptr_next  = pop ? 6'd0 : bit_ptr_reg + 6'd1;
          // The entry's last flag must coincide exactly with the final element.
          if (pop && (head.last_idx != o_elem_last)) err_next = 1'b1;
          if (o_elem_last) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tt_mask_idx_rx.sv
// Directed self-checking bench for tt_mask_idx_rx: one task per scenario,
// with a small transmitter model that pushes items only when holding credit.
module tb_tt_mask_idx_rx;
  import tt_vpu_mask_pkg::*;

  localparam int VLEN         = 256;
  localparam int MASK_CREDITS = 2;
  localparam int VLW          = $clog2(VLEN + 1);

  logic           i_clk = 1'b0;
  logic           i_reset = 1'b1;
  logic           i_start = 1'b0;
  logic           i_is_indexed = 1'b0;
  logic [VLW-1:0] i_vl = '0;
  logic           i_elem_ready = 1'b0;
  logic           o_elem_valid, o_elem_mask, o_elem_last, o_busy, o_protocol_err;
  logic [63:0]    o_elem_index;

  tt_mask_idx_rx_if mask_idx();

  tt_mask_idx_rx #(.VLEN(VLEN), .MASK_CREDITS(MASK_CREDITS)) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .mask_idx       (mask_idx),
    .i_start        (i_start),
    .i_is_indexed   (i_is_indexed),
    .i_vl           (i_vl),
    .o_elem_valid   (o_elem_valid),
    .i_elem_ready   (i_elem_ready),
    .o_elem_mask    (o_elem_mask),
    .o_elem_index   (o_elem_index),
    .o_elem_last    (o_elem_last),
    .o_busy         (o_busy),
    .o_protocol_err (o_protocol_err)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;

  mask_idx_entry_t pend_q[$];
  logic            obs_mask[$];
  logic [63:0]     obs_idx[$];
  logic            obs_last[$];
  int              credit_at[$];
  int              credits_avail;
  int              stall_changes;
  bit              timed_out;

  task automatic do_reset();
    i_reset = 1'b1;
    i_start = 1'b0;
    i_is_indexed = 1'b0;
    i_vl = '0;
    i_elem_ready = 1'b0;
    mask_idx.valid = 1'b0;
    mask_idx.item = '0;
    mask_idx.last_idx = 1'b0;
    credits_avail = MASK_CREDITS;
    pend_q.delete();
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
  endtask

  task automatic push_now(input logic [64:0] item, input logic last);
    mask_idx.valid = 1'b1;
    mask_idx.item = item;
    mask_idx.last_idx = last;
  endtask

  task automatic drive_push();
    mask_idx_entry_t e;
    if (credits_avail > 0 && pend_q.size() > 0) begin
      e = pend_q.pop_front();
      push_now(e.item, e.last_idx);
      credits_avail--;
    end else begin
      mask_idx.valid = 1'b0;
    end
  endtask

  // Runs one memop from pend_q, recording each consumed element and the
  // element count at which each credit pulse is seen.
  task automatic run_memop(input bit indexed, input int vl, input bit toggle_ready);
    bit          stalled;
    logic        sm, sl;
    logic [63:0] si;
    int          n_cons, cyc, tail;
    obs_mask.delete(); obs_idx.delete(); obs_last.delete(); credit_at.delete();
    stall_changes = 0; stalled = 0; n_cons = 0; cyc = 0; tail = 0;
    sm = 1'b0; sl = 1'b0; si = '0;
    @(negedge i_clk);
    i_start = 1'b1; i_is_indexed = indexed; i_vl = VLW'(vl);
    i_elem_ready = 1'b1;
    drive_push();
    while (tail < 3 && cyc < 2000) begin
      @(negedge i_clk);
      cyc++;
      i_start = 1'b0;
      if (mask_idx.credit === 1'b1) begin
        credit_at.push_back(n_cons);
        credits_avail++;
      end
      i_elem_ready = toggle_ready ? ~i_elem_ready : 1'b1;
      if (stalled && o_elem_valid &&
          (o_elem_mask !== sm || o_elem_index !== si || o_elem_last !== sl))
        stall_changes++;
      if (o_elem_valid === 1'b1 && i_elem_ready) begin
        obs_mask.push_back(o_elem_mask);
        obs_idx.push_back(o_elem_index);
        obs_last.push_back(o_elem_last);
        n_cons++;
      end
      stalled = (o_elem_valid === 1'b1) && !i_elem_ready;
      sm = o_elem_mask; si = o_elem_index; sl = o_elem_last;
      drive_push();
      if (n_cons >= vl) tail++;
    end
    timed_out = (cyc >= 2000);
    i_elem_ready = 1'b0;
    mask_idx.valid = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    #2;
    n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    do_reset();
    #1;
    n_cmp++; if (o_elem_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", o_elem_valid); end
    n_cmp++; if (mask_idx.credit !== 1'b0) begin n_err++; $display("FAIL reset_credit: got %b want 0", mask_idx.credit); end
    n_cmp++; if (o_protocol_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", o_protocol_err); end
    n_cmp++; if ({o_elem_mask, o_elem_last, o_elem_index} !== 66'd0) begin n_err++;
      $display("FAIL reset_elem: got mask=%b last=%b idx=%h want 0", o_elem_mask, o_elem_last, o_elem_index); end
    $display("test_reset done");
  endtask

  task automatic test_nonindexed();
    logic [63:0] ch [3];
    logic        exp_m;
    int          mm;
    do_reset();
    ch[0] = 64'hA5A5_0F0F_1234_8001;
    ch[1] = 64'hFFFF_0000_DEAD_BEEF;
    ch[2] = 64'h0000_0000_0000_0002;
    pend_q.push_back('{last_idx: 1'b0, item: {1'b0, ch[0]}});
    pend_q.push_back('{last_idx: 1'b0, item: {1'b0, ch[1]}});
    pend_q.push_back('{last_idx: 1'b1, item: {1'b0, ch[2]}});
    run_memop(1'b0, 130, 1'b0);
    n_cmp++; if (timed_out) begin n_err++; $display("FAIL nonidx_timeout: got timeout want completion"); end
    n_cmp++; if (obs_mask.size() != 130) begin n_err++; $display("FAIL nonidx_count: got %0d want 130", obs_mask.size()); end
    mm = 0;
    for (int e = 0; e < obs_mask.size() && e < 130; e++) begin
      exp_m = ch[e / 64][e % 64];
      if (obs_mask[e] !== exp_m || obs_idx[e] !== 64'd0 || obs_last[e] !== (e == 129)) begin
        mm++;
        $display("FAIL nonidx_elem%0d: got mask=%b idx=%h last=%b want mask=%b idx=0 last=%b",
                 e, obs_mask[e], obs_idx[e], obs_last[e], exp_m, (e == 129));
      end
    end
    n_cmp++; if (mm != 0) n_err++;
    n_cmp++; if (credit_at.size() != 3 || credit_at[0] != 64 || credit_at[1] != 128 || credit_at[2] != 130) begin
      n_err++; $display("FAIL nonidx_credits: got %p want '{64,128,130}", credit_at); end
    n_cmp++; if (o_protocol_err !== 1'b0 || o_busy !== 1'b0) begin n_err++;
      $display("FAIL nonidx_end: got err=%b busy=%b want 0 0", o_protocol_err, o_busy); end
    $display("test_nonindexed done: %0d elements, %0d credits", obs_mask.size(), credit_at.size());
  endtask

  task automatic test_indexed();
    logic [63:0] exp_i [4];
    logic        exp_m [4];
    int          mm;
    do_reset();
    exp_i[0] = 64'h10; exp_i[1] = 64'h20; exp_i[2] = 64'h30; exp_i[3] = 64'h40;
    exp_m[0] = 1'b1;   exp_m[1] = 1'b1;   exp_m[2] = 1'b1;   exp_m[3] = 1'b0;
    for (int k = 0; k < 4; k++)
      pend_q.push_back('{last_idx: (k == 3), item: {exp_m[k], exp_i[k]}});
    run_memop(1'b1, 4, 1'b0);
    n_cmp++; if (timed_out || obs_idx.size() != 4) begin n_err++;
      $display("FAIL idx_count: got %0d timeout=%b want 4 0", obs_idx.size(), timed_out); end
    mm = 0;
    for (int k = 0; k < obs_idx.size() && k < 4; k++) begin
      if (obs_idx[k] !== exp_i[k] || obs_mask[k] !== exp_m[k] || obs_last[k] !== (k == 3)) begin
        mm++;
        $display("FAIL idx_elem%0d: got idx=%h mask=%b last=%b want idx=%h mask=%b last=%b",
                 k, obs_idx[k], obs_mask[k], obs_last[k], exp_i[k], exp_m[k], (k == 3));
      end
    end
    n_cmp++; if (mm != 0) n_err++;
    n_cmp++; if (credit_at.size() != 4 || credit_at[0] != 1 || credit_at[3] != 4) begin n_err++;
      $display("FAIL idx_credits: got %p want '{1,2,3,4}", credit_at); end
    n_cmp++; if (o_protocol_err !== 1'b0) begin n_err++; $display("FAIL idx_err: got %b want 0", o_protocol_err); end
    $display("test_indexed done: %0d elements", obs_idx.size());
  endtask

  task automatic test_back_to_back_stall();
    logic [63:0] exp_i [3];
    logic        exp_m [3];
    int          mm;
    do_reset();
    exp_i[0] = 64'h111; exp_i[1] = 64'h222; exp_i[2] = 64'h333;
    exp_m[0] = 1'b0;    exp_m[1] = 1'b1;    exp_m[2] = 1'b1;
    for (int k = 0; k < 3; k++)
      pend_q.push_back('{last_idx: (k == 2), item: {exp_m[k], exp_i[k]}});
    run_memop(1'b1, 3, 1'b1);
    n_cmp++; if (stall_changes != 0) begin n_err++; $display("FAIL stall_stable: got %0d changes want 0", stall_changes); end
    n_cmp++; if (timed_out || obs_idx.size() != 3) begin n_err++;
      $display("FAIL stall_count: got %0d timeout=%b want 3 0", obs_idx.size(), timed_out); end
    mm = 0;
    for (int k = 0; k < obs_idx.size() && k < 3; k++) begin
      if (obs_idx[k] !== exp_i[k] || obs_mask[k] !== exp_m[k] || obs_last[k] !== (k == 2)) begin
        mm++;
        $display("FAIL stall_elem%0d: got idx=%h mask=%b last=%b want idx=%h mask=%b last=%b",
                 k, obs_idx[k], obs_mask[k], obs_last[k], exp_i[k], exp_m[k], (k == 2));
      end
    end
    n_cmp++; if (mm != 0) n_err++;
    n_cmp++; if (o_protocol_err !== 1'b0 || o_busy !== 1'b0) begin n_err++;
      $display("FAIL stall_end: got err=%b busy=%b want 0 0", o_protocol_err, o_busy); end
    $display("test_back_to_back_stall done: %0d elements", obs_idx.size());
  endtask

  task automatic test_overflow();
    do_reset();
    @(negedge i_clk); push_now({1'b1, 64'h100}, 1'b0);
    @(negedge i_clk); push_now({1'b1, 64'h200}, 1'b0);
    @(negedge i_clk); push_now({1'b1, 64'hDEAD}, 1'b0);
    n_cmp++; if (o_protocol_err !== 1'b0) begin n_err++; $display("FAIL ovf_pre: got %b want 0", o_protocol_err); end
    @(negedge i_clk); mask_idx.valid = 1'b0;
    n_cmp++; if (o_protocol_err !== 1'b1) begin n_err++; $display("FAIL ovf_err: got %b want 1", o_protocol_err); end
    i_start = 1'b1; i_is_indexed = 1'b1; i_vl = VLW'(3);
    @(negedge i_clk); i_start = 1'b0;
    n_cmp++; if (o_elem_valid !== 1'b1 || o_elem_index !== 64'h100) begin n_err++;
      $display("FAIL ovf_head0: got valid=%b idx=%h want 1 100", o_elem_valid, o_elem_index); end
    i_elem_ready = 1'b1;
    push_now({1'b0, 64'h300}, 1'b1);
    @(negedge i_clk); mask_idx.valid = 1'b0;
    n_cmp++; if (o_elem_index !== 64'h200 || mask_idx.credit !== 1'b1) begin n_err++;
      $display("FAIL ovf_head1: got idx=%h credit=%b want 200 1", o_elem_index, mask_idx.credit); end
    @(negedge i_clk);
    n_cmp++; if (o_elem_valid !== 1'b1 || o_elem_index !== 64'h300 || o_elem_last !== 1'b1) begin n_err++;
      $display("FAIL ovf_pushpop: got valid=%b idx=%h last=%b want 1 300 1", o_elem_valid, o_elem_index, o_elem_last); end
    @(negedge i_clk); i_elem_ready = 1'b0;
    n_cmp++; if (o_busy !== 1'b0 || o_elem_valid !== 1'b0 || o_protocol_err !== 1'b1) begin n_err++;
      $display("FAIL ovf_end: got busy=%b valid=%b err=%b want 0 0 1", o_busy, o_elem_valid, o_protocol_err); end
    $display("test_overflow done");
  endtask

  task automatic test_last_err();
    do_reset();
    @(negedge i_clk); push_now({1'b1, 64'h1}, 1'b1);
    @(negedge i_clk); push_now({1'b0, 64'h2}, 1'b1);
    i_start = 1'b1; i_is_indexed = 1'b1; i_vl = VLW'(2);
    @(negedge i_clk); mask_idx.valid = 1'b0; i_start = 1'b0; i_elem_ready = 1'b1;
    n_cmp++; if (o_protocol_err !== 1'b0 || o_elem_valid !== 1'b1) begin n_err++;
      $display("FAIL last_pre: got err=%b valid=%b want 0 1", o_protocol_err, o_elem_valid); end
    @(negedge i_clk);
    n_cmp++; if (o_protocol_err !== 1'b1 || o_busy !== 1'b1 || o_elem_index !== 64'h2 || o_elem_last !== 1'b1) begin
      n_err++; $display("FAIL last_early: got err=%b busy=%b idx=%h last=%b want 1 1 2 1",
                        o_protocol_err, o_busy, o_elem_index, o_elem_last); end
    @(negedge i_clk); i_elem_ready = 1'b0;
    n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL last_idle: got busy=%b want 0", o_busy); end
    $display("test_last_err done");
  endtask

  task automatic test_start_active();
    do_reset();
    @(negedge i_clk); i_start = 1'b1; i_is_indexed = 1'b1; i_vl = '0;
    @(negedge i_clk); i_start = 1'b0;
    n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL start_vl0: got busy=%b want 0", o_busy); end
    push_now({1'b1, 64'h5}, 1'b1);
    i_start = 1'b1; i_vl = VLW'(2);
    @(negedge i_clk); i_start = 1'b0; mask_idx.valid = 1'b0;
    n_cmp++; if (o_busy !== 1'b1 || o_protocol_err !== 1'b0) begin n_err++;
      $display("FAIL start_go: got busy=%b err=%b want 1 0", o_busy, o_protocol_err); end
    i_start = 1'b1; i_vl = VLW'(1);
    @(negedge i_clk); i_start = 1'b0;
    n_cmp++; if (o_protocol_err !== 1'b1 || o_busy !== 1'b1 || o_elem_last !== 1'b0) begin n_err++;
      $display("FAIL start_active: got err=%b busy=%b last=%b want 1 1 0", o_protocol_err, o_busy, o_elem_last); end
    $display("test_start_active done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge i_clk); push_now({1'b1, 64'hA}, 1'b0);
    i_start = 1'b1; i_is_indexed = 1'b1; i_vl = VLW'(4); i_elem_ready = 1'b1;
    @(negedge i_clk); i_start = 1'b0; push_now({1'b1, 64'hB}, 1'b0);
    @(negedge i_clk); push_now({1'b1, 64'hC}, 1'b0);
    @(negedge i_clk); mask_idx.valid = 1'b0;
    n_cmp++; if (mask_idx.credit !== 1'b1 || o_busy !== 1'b1 || o_elem_valid !== 1'b1 || o_elem_index !== 64'hC) begin
      n_err++; $display("FAIL mid_pre: got credit=%b busy=%b valid=%b idx=%h want 1 1 1 c",
                        mask_idx.credit, o_busy, o_elem_valid, o_elem_index); end
    #1 i_reset = 1'b1;
    #1;
    n_cmp++; if (o_busy !== 1'b0 || o_elem_valid !== 1'b0 || mask_idx.credit !== 1'b0) begin n_err++;
      $display("FAIL mid_reset: got busy=%b valid=%b credit=%b want 0 0 0", o_busy, o_elem_valid, mask_idx.credit); end
    @(negedge i_clk); i_reset = 1'b0; i_elem_ready = 1'b0;
    i_start = 1'b1; i_vl = VLW'(1);
    @(negedge i_clk); i_start = 1'b0;
    n_cmp++; if (o_busy !== 1'b1 || o_elem_valid !== 1'b0) begin n_err++;
      $display("FAIL mid_empty: got busy=%b valid=%b want 1 0", o_busy, o_elem_valid); end
    do_reset();
    $display("test_reset_mid done");
  endtask

  initial begin
    mask_idx.valid = 1'b0;
    mask_idx.item = '0;
    mask_idx.last_idx = 1'b0;
    credits_avail = MASK_CREDITS;
    test_reset();
    test_nonindexed();
    test_indexed();
    test_back_to_back_stall();
    test_overflow();
    test_last_err();
    test_start_active();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by time limit, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
